// File: rtl/bp_be_pkg.sv
// Backend shared types: FE command layout and scheduler state.
// Sized by a processor configuration enum.
package bp_be_pkg;

  typedef enum logic {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_icache_fence         = 3'd2,
    e_op_icache_fill_response = 3'd3,
    e_op_wait                 = 3'd4,
    e_op_attaboy              = 3'd5,
    e_op_branch_mispredict    = 3'd6
  } bp_fe_cmd_opcode_e;

  typedef struct packed {
    bp_fe_cmd_opcode_e opcode;
    logic [38:0]       npc;
  } bp_fe_cmd_s;

  typedef enum logic {
    e_run   = 1'b0,
    e_fence = 1'b1
  } bp_be_fe_cmd_sched_state_e;

  function automatic int bp_fe_cmd_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? $bits(bp_fe_cmd_s) : 0;
  endfunction

endpackage

// File: rtl/bp_be_fe_cmd_fb_fifo.sv
// Feedback command FIFO: ready-valid in, valid-yumi out.
// Power-of-2 depth; pointers carry a wrap bit; clear_i empties it.
module bp_be_fe_cmd_fb_fifo
  import bp_be_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int lg_lp = $clog2(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [lg_lp:0]     wr_ptr_q, wr_ptr_d;
  logic [lg_lp:0]     rd_ptr_q, rd_ptr_d;
  logic               enq, empty, full;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[lg_lp] != rd_ptr_q[lg_lp])
               & (wr_ptr_q[lg_lp-1:0] == rd_ptr_q[lg_lp-1:0]);

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign enq     = v_i & ~full;
  assign data_o  = mem_q[rd_ptr_q[lg_lp-1:0]];

  // Next pointers; clear drops every entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{lg_lp{1'b0}}, enq};
    rd_ptr_d = rd_ptr_q + {{lg_lp{1'b0}}, yumi_i};
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wr_ptr_q[lg_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_be_fe_cmd_scheduler.sv
// Arbitrates redirect and feedback commands towards the FE.
// Optional drop counter: BP_BE_FE_CMD_SCHED_STATS_EN.
module bp_be_fe_cmd_scheduler
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int fb_els_p = 4,
  localparam int fe_cmd_width_lp = bp_fe_cmd_width(bp_params_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [fe_cmd_width_lp-1:0] redir_cmd_i,
  input  logic                       redir_v_i,
  output logic                       redir_ready_o,
  input  logic [fe_cmd_width_lp-1:0] fb_cmd_i,
  input  logic                       fb_v_i,
  output logic [fe_cmd_width_lp-1:0] fe_cmd_o,
  output logic                       fe_cmd_v_o,
  input  logic                       fe_cmd_yumi_i,
  output logic                       empty_o,
  output logic                       redir_pending_o,
  output logic [15:0]                drop_count_o
);

  bp_be_fe_cmd_sched_state_e state_q, state_d;

  logic                       redir_full_q, redir_full_d;
  logic [fe_cmd_width_lp-1:0] redir_cmd_q, redir_cmd_d;
  logic [fe_cmd_width_lp-1:0] fifo_data;
  logic redir_acc, redir_yumi, fb_yumi, sel_fb;
  logic fifo_v_in, fifo_ready, fifo_v;

  assign redir_ready_o = ~redir_full_q;
  assign redir_acc     = redir_v_i & ~redir_full_q;
  assign sel_fb        = ~redir_full_q & (state_q == e_run) & fifo_v;

  assign fe_cmd_v_o = redir_full_q | sel_fb;
  assign fe_cmd_o   = redir_full_q ? redir_cmd_q : fifo_data;
  assign redir_yumi = fe_cmd_yumi_i & redir_full_q;
  assign fb_yumi    = fe_cmd_yumi_i & sel_fb;

  assign fifo_v_in = fb_v_i & (state_q == e_run) & ~redir_acc & ~reset_i;

  assign empty_o         = ~redir_full_q & ~fifo_v;
  assign redir_pending_o = (state_q == e_fence);

  bp_be_fe_cmd_fb_fifo #(
    .width_p(fe_cmd_width_lp),
    .els_p  (fb_els_p)
  ) fb_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(redir_acc),
    .data_i (fb_cmd_i),
    .v_i    (fifo_v_in),
    .ready_o(fifo_ready),
    .data_o (fifo_data),
    .v_o    (fifo_v),
    .yumi_i (fb_yumi)
  );

  // Fence on redirect accept; resume once the FE takes it.
  always_comb begin
    state_d      = state_q;
    redir_full_d = redir_full_q;
    redir_cmd_d  = redir_cmd_q;
    unique case (state_q)
      e_run: if (redir_acc) begin
        state_d      = e_fence;
        redir_full_d = 1'b1;
        redir_cmd_d  = redir_cmd_i;
      end
      e_fence: if (redir_yumi) begin
        state_d      = e_run;
        redir_full_d = 1'b0;
      end
      default: state_d = e_run;
    endcase
  end

  // State and redirect slot registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_run;
      redir_full_q <= 1'b0;
      redir_cmd_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_full_q <= redir_full_d;
      redir_cmd_q  <= redir_cmd_d;
    end
  end

`ifdef BP_BE_FE_CMD_SCHED_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  assign drop = fb_v_i & ~(fifo_v_in & fifo_ready);

  // Saturating count of discarded feedback.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

`ifndef SYNTHESIS
  a_yumi_v: assert property (
    @(posedge clk_i) disable iff (reset_i)
    fe_cmd_yumi_i |-> fe_cmd_v_o
  ) else $error("fe_cmd_yumi_i without fe_cmd_v_o");
`endif

endmodule

// File: tb/tb_bp_be_fe_cmd_scheduler.sv
// Scoreboard bench for the FE command scheduler.
// Covers reset, redirects, feedback queueing, drops.
module tb_bp_be_fe_cmd_scheduler;
  import bp_be_pkg::*;

  localparam int W = $bits(bp_fe_cmd_s);

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] redir_cmd_i, fb_cmd_i, fe_cmd_o;
  logic         redir_v_i, redir_ready_o, fb_v_i;
  logic         fe_cmd_v_o, fe_cmd_yumi_i, empty_o, redir_pending_o;
  logic [15:0]  drop_count_o;

  bp_fe_cmd_s exp_q[$];
  bp_fe_cmd_s cmd_a, cmd_b;
  logic [15:0] exp_drop;
  int n_tests = 0;
  int n_fail  = 0;

  bp_be_fe_cmd_scheduler #(
    .bp_params_p(e_bp_default_cfg),
    .fb_els_p   (4)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .redir_cmd_i    (redir_cmd_i),
    .redir_v_i      (redir_v_i),
    .redir_ready_o  (redir_ready_o),
    .fb_cmd_i       (fb_cmd_i),
    .fb_v_i         (fb_v_i),
    .fe_cmd_o       (fe_cmd_o),
    .fe_cmd_v_o     (fe_cmd_v_o),
    .fe_cmd_yumi_i  (fe_cmd_yumi_i),
    .empty_o        (empty_o),
    .redir_pending_o(redir_pending_o),
    .drop_count_o   (drop_count_o)
  );

  always #5 clk = ~clk;

  function automatic bp_fe_cmd_s mk(bp_fe_cmd_opcode_e op,
                                    logic [38:0] npc);
    bp_fe_cmd_s c;
    c.opcode = op;
    c.npc    = npc;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
`ifdef BP_BE_FE_CMD_SCHED_STATS_EN
    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
  endtask

  task automatic drain(input string tag, input int budget);
    bp_fe_cmd_s e;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      if (fe_cmd_v_o) begin
        e = exp_q.pop_front();
        chk(tag, fe_cmd_o, e);
        fe_cmd_yumi_i = 1'b1;
        tick();
        fe_cmd_yumi_i = 1'b0;
      end else begin
        tick();
      end
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    chk({tag, "_idle"}, fe_cmd_v_o, 1'b0);
    chk({tag, "_empty"}, empty_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    redir_cmd_i = '0; redir_v_i = 1'b0;
    fb_cmd_i = '0; fb_v_i = 1'b0;
    fe_cmd_yumi_i = 1'b0;
    exp_drop = '0;
    tick(); tick();
    reset_i = 1'b0;
    chk("rst_v", fe_cmd_v_o, 1'b0);
    chk("rst_ready", redir_ready_o, 1'b1);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_pend", redir_pending_o, 1'b0);
    chk("rst_drop", drop_count_o, 16'h0);

    // Single redirect: visible next cycle, gone after yumi.
    cmd_a = mk(e_op_pc_redirection, 39'h8000_0000);
    redir_cmd_i = cmd_a; redir_v_i = 1'b1;
    exp_q.push_back(cmd_a);
    tick();
    redir_v_i = 1'b0;
    chk("s1_v", fe_cmd_v_o, 1'b1);
    chk("s1_pend", redir_pending_o, 1'b1);
    chk("s1_ready", redir_ready_o, 1'b0);
    chk("s1_cmd", fe_cmd_o, exp_q.pop_front());
    fe_cmd_yumi_i = 1'b1;
    tick();
    fe_cmd_yumi_i = 1'b0;
    chk("s1_empty", empty_o, 1'b1);
    chk("s1_run", redir_pending_o, 1'b0);
    chk("s1_ready2", redir_ready_o, 1'b1);

    // Five attaboys into a 4-deep FIFO: last one dropped.
    for (int i = 0; i < 5; i++) begin
      fb_cmd_i = mk(e_op_attaboy, 39'h100 + 39'(i));
      fb_v_i = 1'b1;
      if (i < 4) exp_q.push_back(mk(e_op_attaboy, 39'h100 + 39'(i)));
      else bump();
      tick();
    end
    fb_v_i = 1'b0;
    chk("s2_drop", drop_count_o, exp_drop);
    chk("s2_v", fe_cmd_v_o, 1'b1);
    drain("s2_cmd", 20);

    // Queued feedback flushed by a redirect; fence drops feedback.
    for (int i = 0; i < 3; i++) begin
      fb_cmd_i = mk(e_op_attaboy, 39'h200 + 39'(i));
      fb_v_i = 1'b1;
      exp_q.push_back(mk(e_op_attaboy, 39'h200 + 39'(i)));
      tick();
    end
    fb_v_i = 1'b0;
    cmd_a = mk(e_op_pc_redirection, 39'h4000);
    redir_cmd_i = cmd_a; redir_v_i = 1'b1;
    exp_q.delete();
    exp_q.push_back(cmd_a);
    tick();
    redir_v_i = 1'b0;
    chk("s3_pend", redir_pending_o, 1'b1);
    fb_cmd_i = mk(e_op_branch_mispredict, 39'h300);
    fb_v_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bump();
      tick();
    end
    fb_v_i = 1'b0;
    chk("s3_drop", drop_count_o, exp_drop);
    drain("s3_cmd", 10);

    // Redirect and attaboy together: attaboy lost.
    cmd_a = mk(e_op_icache_fence, 39'h5000);
    redir_cmd_i = cmd_a; redir_v_i = 1'b1;
    fb_cmd_i = mk(e_op_attaboy, 39'h500); fb_v_i = 1'b1;
    exp_q.push_back(cmd_a);
    bump();
    tick();
    redir_v_i = 1'b0; fb_v_i = 1'b0;
    chk("s4_drop", drop_count_o, exp_drop);
    drain("s4_cmd", 10);

    // Second redirect blocked until the first is taken.
    cmd_a = mk(e_op_pc_redirection, 39'h1000);
    cmd_b = mk(e_op_wait, 39'h2000);
    redir_cmd_i = cmd_a; redir_v_i = 1'b1;
    tick();
    redir_cmd_i = cmd_b;
    chk("s5_ready0", redir_ready_o, 1'b0);
    tick();
    chk("s5_ready1", redir_ready_o, 1'b0);
    chk("s5_first", fe_cmd_o, cmd_a);
    fe_cmd_yumi_i = 1'b1;
    tick();
    fe_cmd_yumi_i = 1'b0;
    chk("s5_gap_v", fe_cmd_v_o, 1'b0);
    chk("s5_gap_ready", redir_ready_o, 1'b1);
    exp_q.push_back(cmd_b);
    tick();
    redir_v_i = 1'b0;
    chk("s5_second_v", fe_cmd_v_o, 1'b1);
    drain("s5_cmd", 10);

    // Drops near saturation.
`ifdef BP_BE_FE_CMD_SCHED_STATS_EN
    force dut.drop_cnt_q = 16'hFFFE;
    #1;
    release dut.drop_cnt_q;
    exp_drop = 16'hFFFE;
`endif
    cmd_a = mk(e_op_state_reset, 39'h0);
    redir_cmd_i = cmd_a; redir_v_i = 1'b1;
    fb_cmd_i = mk(e_op_attaboy, 39'h600); fb_v_i = 1'b1;
    exp_q.push_back(cmd_a);
    for (int i = 0; i < 3; i++) begin
      bump();
      tick();
      redir_v_i = 1'b0;
    end
    fb_v_i = 1'b0;
    chk("s6_drop", drop_count_o, exp_drop);
    drain("s6_cmd", 10);

    // Reset mid-operation with active inputs.
    fb_cmd_i = mk(e_op_attaboy, 39'h700); fb_v_i = 1'b1;
    tick(); tick();
    redir_cmd_i = mk(e_op_pc_redirection, 39'h7000);
    redir_v_i = 1'b1;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; redir_v_i = 1'b0; fb_v_i = 1'b0;
    exp_q.delete();
    exp_drop = '0;
    chk("s7_v", fe_cmd_v_o, 1'b0);
    chk("s7_ready", redir_ready_o, 1'b1);
    chk("s7_empty", empty_o, 1'b1);
    chk("s7_pend", redir_pending_o, 1'b0);
    chk("s7_drop", drop_count_o, exp_drop);
    tick();
    chk("s7_still_empty", empty_o, 1'b1);

    // Normal service after the mid-run reset.
    fb_cmd_i = mk(e_op_attaboy, 39'h800); fb_v_i = 1'b1;
    exp_q.push_back(mk(e_op_attaboy, 39'h800));
    tick();
    fb_v_i = 1'b0;
    drain("s8_cmd", 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
